// File: rtl/tr_rule_engine.sv
// Rule-inference stage of the interval type-2 fuzzy controller: evaluates a 3x3
// rule base one rule per clock (min t-norm, max aggregation) and strobes EN_saida.
module tr_rule_engine #(
  parameter logic [17:0] RULE_TABLE = 18'h29910,
  parameter int          N_RULES    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] E_UP,
  input  logic [23:0] E_LOW,
  input  logic [23:0] DE_UP,
  input  logic [23:0] DE_LOW,
  output logic [7:0]  FOU_1_UP,
  output logic [7:0]  FOU_2_UP,
  output logic [7:0]  FOU_3_UP,
  output logic [7:0]  FOU_1_LOW,
  output logic [7:0]  FOU_2_LOW,
  output logic [7:0]  FOU_3_LOW,
  output logic        EN_saida,
  output logic        busy
);

  typedef enum logic {IDLE, EVAL} state_t;

  localparam logic [3:0] LAST_RULE = 4'(N_RULES - 1);

  state_t      state_q, state_d;
  logic [3:0]  rule_q, rule_d;
  logic [23:0] e_up_q, e_up_d, e_low_q, e_low_d;
  logic [23:0] de_up_q, de_up_d, de_low_q, de_low_d;
  logic [7:0]  acc_up_q [3];
  logic [7:0]  acc_up_d [3];
  logic [7:0]  acc_low_q [3];
  logic [7:0]  acc_low_d [3];
  logic [7:0]  fou_up_q [3];
  logic [7:0]  fou_up_d [3];
  logic [7:0]  fou_low_q [3];
  logic [7:0]  fou_low_d [3];
  logic        en_q, en_d;
  logic        busy_q, busy_d;

  logic [1:0]  cons_tbl [N_RULES];
  logic [1:0]  cons;
  logic [1:0]  i_idx, j_idx;
  logic [7:0]  e_up_i, e_low_i, de_up_j, de_low_j;
  logic [7:0]  fire_up, low_raw, fire_low;

  for (genvar gi = 0; gi < N_RULES; gi++) begin : g_cons
    assign cons_tbl[gi] = RULE_TABLE[2*gi +: 2];
  end

  // Rule r maps to E set r/3 and DE set r%3.
  always_comb begin
    if (rule_q >= 4'd6) begin
      i_idx = 2'd2;
      j_idx = 2'(rule_q - 4'd6);
    end else if (rule_q >= 4'd3) begin
      i_idx = 2'd1;
      j_idx = 2'(rule_q - 4'd3);
    end else begin
      i_idx = 2'd0;
      j_idx = rule_q[1:0];
    end
  end

  assign cons     = cons_tbl[rule_q];
  assign e_up_i   = e_up_q  [{i_idx, 3'b000} +: 8];
  assign e_low_i  = e_low_q [{i_idx, 3'b000} +: 8];
  assign de_up_j  = de_up_q [{j_idx, 3'b000} +: 8];
  assign de_low_j = de_low_q[{j_idx, 3'b000} +: 8];

  assign fire_up  = (e_up_i < de_up_j) ? e_up_i : de_up_j;
  assign low_raw  = (e_low_i < de_low_j) ? e_low_i : de_low_j;
  // Lower firing must stay inside the footprint, so clamp to the upper firing.
  assign fire_low = (low_raw < fire_up) ? low_raw : fire_up;

  always_comb begin
    state_d   = state_q;
    rule_d    = rule_q;
    e_up_d    = e_up_q;
    e_low_d   = e_low_q;
    de_up_d   = de_up_q;
    de_low_d  = de_low_q;
    acc_up_d  = acc_up_q;
    acc_low_d = acc_low_q;
    fou_up_d  = fou_up_q;
    fou_low_d = fou_low_q;
    en_d      = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          e_up_d    = E_UP;
          e_low_d   = E_LOW;
          de_up_d   = DE_UP;
          de_low_d  = DE_LOW;
          acc_up_d  = '{default: '0};
          acc_low_d = '{default: '0};
          rule_d    = 4'd0;
          busy_d    = 1'b1;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        for (int k = 0; k < 3; k++) begin
          if (cons == 2'(k)) begin
            if (fire_up > acc_up_q[k])   acc_up_d[k]  = fire_up;
            if (fire_low > acc_low_q[k]) acc_low_d[k] = fire_low;
          end
        end
        rule_d = rule_q + 4'd1;
        // Final rule: publish aggregates including this rule's contribution.
        if (rule_q == LAST_RULE) begin
          fou_up_d  = acc_up_d;
          fou_low_d = acc_low_d;
          en_d      = 1'b1;
          busy_d    = 1'b0;
          rule_d    = 4'd0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rule_q    <= 4'd0;
      e_up_q    <= '0;
      e_low_q   <= '0;
      de_up_q   <= '0;
      de_low_q  <= '0;
      acc_up_q  <= '{default: '0};
      acc_low_q <= '{default: '0};
      fou_up_q  <= '{default: '0};
      fou_low_q <= '{default: '0};
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rule_q    <= rule_d;
      e_up_q    <= e_up_d;
      e_low_q   <= e_low_d;
      de_up_q   <= de_up_d;
      de_low_q  <= de_low_d;
      acc_up_q  <= acc_up_d;
      acc_low_q <= acc_low_d;
      fou_up_q  <= fou_up_d;
      fou_low_q <= fou_low_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
    end
  end

  assign FOU_1_UP  = fou_up_q[0];
  assign FOU_2_UP  = fou_up_q[1];
  assign FOU_3_UP  = fou_up_q[2];
  assign FOU_1_LOW = fou_low_q[0];
  assign FOU_2_LOW = fou_low_q[1];
  assign FOU_3_LOW = fou_low_q[2];
  assign EN_saida  = en_q;
  assign busy      = busy_q;

endmodule
